// File: rtl/pipe_pkg.sv
// Shared constants for the CPU inter-stage pipeline registers.
package pipe_pkg;

  // Control payload bit positions
  localparam int unsigned CTRL_ALUSRC    = 0;
  localparam int unsigned CTRL_MEMTOREG  = 1;
  localparam int unsigned CTRL_REGWRITE  = 2;
  localparam int unsigned CTRL_MEMWRITE  = 3;
  localparam int unsigned CTRL_MEMREAD   = 4;
  localparam int unsigned CTRL_ALUOP_LSB = 5;

  localparam int unsigned CTRL_W_DEFAULT = 7;

  // Data payload width per stage boundary
  localparam int unsigned DATA_W_IF_ID  = 64;  // pc + instruction
  localparam int unsigned DATA_W_ID_EX  = 96;  // rs data + rt data + immediate
  localparam int unsigned DATA_W_EX_MEM = 64;  // alu result + store data
  localparam int unsigned DATA_W_MEM_WB = 64;  // load data + alu result

endpackage

// File: rtl/pipe_entry.sv
// One valid+payload register slot with load, clear and synchronous reset.
module pipe_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Clear only drops the valid bit; the payload keeps its last value
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with flush and optional two-entry skid.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_ID_EX,
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occ_o
);

  localparam int unsigned PW = DATA_W + CTRL_W;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] m_pl;
  logic [PW-1:0] m_d;
  logic          m_valid;
  logic          m_load;
  logic          m_clear;
  logic          in_xfer;
  logic          out_xfer;

  assign in_pl    = {ctrl_i, data_i};
  assign in_xfer  = valid_i & ready_o & ~flush_i;
  assign out_xfer = m_valid & ready_i;

  // Main entry: drives the downstream outputs
  pipe_entry #(.W(PW)) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_valid),
    .q     (m_pl)
  );

  if (SKID != 0) begin : g_skid
    logic          s_valid;
    logic          s_load;
    logic          s_clear;
    logic [PW-1:0] s_pl;

    // Skid entry: catches the payload accepted while main is stalled
    pipe_entry #(.W(PW)) u_skid (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load  (s_load),
      .clear (s_clear),
      .d     (in_pl),
      .valid (s_valid),
      .q     (s_pl)
    );

    assign ready_o = ~s_valid;
    assign occ_o   = 2'(m_valid) + 2'(s_valid);

    // Flush first, then refill main (skid before input), else park input in skid
    always_comb begin
      m_load  = 1'b0;
      m_clear = 1'b0;
      m_d     = in_pl;
      s_load  = 1'b0;
      s_clear = 1'b0;
      if (flush_i) begin
        m_clear = 1'b1;
        s_clear = 1'b1;
      end else if (!m_valid || out_xfer) begin
        if (s_valid) begin
          m_load  = 1'b1;
          m_d     = s_pl;
          s_clear = 1'b1;
        end else if (in_xfer) begin
          m_load = 1'b1;
        end else begin
          m_clear = 1'b1;
        end
      end else if (in_xfer) begin
        s_load = 1'b1;
      end
    end
  end else begin : g_single
    assign ready_o = ~m_valid | ready_i;
    assign occ_o   = 2'(m_valid);

    // Single register: flush, else load on accept, else drain on downstream take
    always_comb begin
      m_load  = 1'b0;
      m_clear = 1'b0;
      m_d     = in_pl;
      if (flush_i) begin
        m_clear = 1'b1;
      end else if (in_xfer) begin
        m_load = 1'b1;
      end else if (out_xfer) begin
        m_clear = 1'b1;
      end
    end
  end

  // Bubbles carry an all-zero control word so no write enable can fire
  assign valid_o = m_valid;
  assign data_o  = m_pl[DATA_W-1:0];
  assign ctrl_o  = m_pl[PW-1:DATA_W] & {CTRL_W{m_valid}};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: scoreboard on the skid instance plus directed checks.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = DATA_W_ID_EX;
  localparam int unsigned CW = CTRL_W_DEFAULT;
  localparam int unsigned ZW = DATA_W_IF_ID;
  localparam int unsigned PW = DW + CW;
  localparam logic [CW-1:0] CTRL_ALL = CW'((1 << CTRL_ALUSRC) | (1 << CTRL_MEMTOREG) |
                                           (1 << CTRL_REGWRITE) | (1 << CTRL_MEMWRITE) |
                                           (1 << CTRL_MEMREAD) | (3 << CTRL_ALUOP_LSB));
  localparam logic [CW-1:0] CTRL_RW = CW'(1 << CTRL_REGWRITE);

  logic clk = 1'b0;
  logic rst_i;

  logic          valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [DW-1:0] data_i, data_o;
  logic [CW-1:0] ctrl_i, ctrl_o;
  logic [1:0]    occ_o;

  logic          z_valid_i, z_ready_o, z_flush_i, z_valid_o, z_ready_i;
  logic [ZW-1:0] z_data_i, z_data_o;
  logic [CW-1:0] z_ctrl_i, z_ctrl_o;
  logic [1:0]    z_occ_o;

  int checks = 0;
  int passed = 0;
  logic [PW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .ctrl_i(ctrl_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o), .occ_o(occ_o)
  );

  pipe_stage_skid #(.DATA_W(ZW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(z_valid_i), .ready_o(z_ready_o),
    .data_i(z_data_i), .ctrl_i(z_ctrl_i), .flush_i(z_flush_i), .valid_o(z_valid_o),
    .ready_i(z_ready_i), .data_o(z_data_o), .ctrl_o(z_ctrl_o), .occ_o(z_occ_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops and compares every downstream transfer; pushes every upstream accept
  task automatic monitor();
    logic [PW-1:0] exp;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        if (valid_o && ready_i) begin
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got payload %h, none expected", {ctrl_o, data_o});
          end else begin
            exp = sb.pop_front();
            if ({ctrl_o, data_o} !== exp)
              $display("FAIL sb_payload: got %h want %h", {ctrl_o, data_o}, exp);
            else passed++;
          end
        end
        if (flush_i) sb.delete();
        else if (valid_i && ready_o) sb.push_back({ctrl_i, data_i});
      end else begin
        sb.delete();
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; valid_i = 1'b1; ctrl_i = CTRL_ALL; data_i = DW'(32'hABC);
    ready_i = 1'b0; flush_i = 1'b0;
    z_valid_i = 1'b1; z_ctrl_i = CTRL_ALL; z_data_i = ZW'(32'h55); z_ready_i = 1'b0; z_flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid_o); else passed++;
    checks++; if (ctrl_o !== '0) $display("FAIL rst_ctrl: got %h want 0", ctrl_o); else passed++;
    checks++; if (data_o !== '0) $display("FAIL rst_data: got %h want 0", data_o); else passed++;
    checks++; if (occ_o !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occ_o); else passed++;
    checks++; if (z_valid_o !== 1'b0) $display("FAIL rst_z_valid: got %0b want 0", z_valid_o); else passed++;
    rst_i = 1'b1; valid_i = 1'b0; z_valid_i = 1'b0;
    tick();
    checks++; if (ready_o !== 1'b1) $display("FAIL rst_ready: got %0b want 1", ready_o); else passed++;
    checks++; if (z_ready_o !== 1'b1) $display("FAIL rst_z_ready: got %0b want 1", z_ready_o); else passed++;
  endtask

  task automatic test_stream();
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      valid_i = 1'b1; data_i = DW'(i); ctrl_i = CW'(i);
      tick();
      checks++; if (valid_o !== 1'b1) $display("FAIL stream_valid%0d: got %0b want 1", i, valid_o); else passed++;
      checks++; if (data_o !== DW'(i)) $display("FAIL stream_data%0d: got %0d want %0d", i, data_o, i); else passed++;
      checks++; if (occ_o !== 2'd1) $display("FAIL stream_occ%0d: got %0d want 1", i, occ_o); else passed++;
    end
    valid_i = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0) $display("FAIL stream_end_valid: got %0b want 0", valid_o); else passed++;
    checks++; if (ctrl_o !== '0) $display("FAIL stream_end_ctrl: got %h want 0", ctrl_o); else passed++;
  endtask

  task automatic test_backpressure();
    ctrl_i = CTRL_ALL; ready_i = 1'b1; valid_i = 1'b1; data_i = DW'(1);
    tick();
    ready_i = 1'b0; data_i = DW'(2);
    tick();
    checks++; if (occ_o !== 2'd2) $display("FAIL bp_occ2: got %0d want 2", occ_o); else passed++;
    checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready: got %0b want 0", ready_o); else passed++;
    checks++; if (data_o !== DW'(1)) $display("FAIL bp_hold1: got %0d want 1", data_o); else passed++;
    data_i = DW'(3);
    tick();
    checks++; if (occ_o !== 2'd2) $display("FAIL bp_stall_occ: got %0d want 2", occ_o); else passed++;
    ready_i = 1'b1;
    tick();
    checks++; if (data_o !== DW'(2)) $display("FAIL bp_out2: got %0d want 2", data_o); else passed++;
    checks++; if (occ_o !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", occ_o); else passed++;
    tick();
    checks++; if (data_o !== DW'(3)) $display("FAIL bp_out3: got %0d want 3", data_o); else passed++;
    valid_i = 1'b0;
    tick();
    checks++; if (valid_o !== 1'b0) $display("FAIL bp_drained: got %0b want 0", valid_o); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL bp_lost: got %0d pending want 0", sb.size()); else passed++;
  endtask

  task automatic test_flush();
    ready_i = 1'b0; ctrl_i = CTRL_RW; valid_i = 1'b1; data_i = DW'(10);
    tick();
    data_i = DW'(11);
    tick();
    checks++; if (occ_o !== 2'd2) $display("FAIL fl_occ_pre: got %0d want 2", occ_o); else passed++;
    data_i = DW'(12); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) $display("FAIL fl_valid: got %0b want 0", valid_o); else passed++;
    checks++; if (ctrl_o !== '0) $display("FAIL fl_ctrl: got %h want 0", ctrl_o); else passed++;
    checks++; if (occ_o !== 2'd0) $display("FAIL fl_occ: got %0d want 0", occ_o); else passed++;
    ready_i = 1'b1; valid_i = 1'b1; data_i = DW'(13); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) $display("FAIL fl_reject: got %0b want 0", valid_o); else passed++;
    repeat (2) tick();
    checks++; if (valid_o !== 1'b0) $display("FAIL fl_quiet: got %0b want 0", valid_o); else passed++;
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0; ctrl_i = CTRL_ALL; valid_i = 1'b1; data_i = DW'(20);
    tick();
    data_i = DW'(21);
    tick();
    checks++; if (occ_o !== 2'd2) $display("FAIL rm_occ_pre: got %0d want 2", occ_o); else passed++;
    rst_i = 1'b0; data_i = DW'(22);
    tick();
    rst_i = 1'b1; valid_i = 1'b0;
    checks++; if (occ_o !== 2'd0) $display("FAIL rm_occ: got %0d want 0", occ_o); else passed++;
    checks++; if (data_o !== '0) $display("FAIL rm_data: got %h want 0", data_o); else passed++;
    checks++; if (ready_o !== 1'b1) $display("FAIL rm_ready: got %0b want 1", ready_o); else passed++;
    valid_i = 1'b1; data_i = DW'(9); ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    checks++; if (data_o !== DW'(9) || valid_o !== 1'b1)
      $display("FAIL rm_d9: got valid %0b data %0d want valid 1 data 9", valid_o, data_o); else passed++;
    tick();
    checks++; if (valid_o !== 1'b0) $display("FAIL rm_alone: got %0b want 0", valid_o); else passed++;
  endtask

  task automatic test_noskid();
    z_ctrl_i = CTRL_RW; z_ready_i = 1'b0; z_valid_i = 1'b1; z_data_i = ZW'(5);
    tick();
    z_valid_i = 1'b0;
    checks++; if (z_data_o !== ZW'(5)) $display("FAIL ns_d5: got %0d want 5", z_data_o); else passed++;
    checks++; if (z_ready_o !== 1'b0) $display("FAIL ns_ready_low: got %0b want 0", z_ready_o); else passed++;
    z_ready_i = 1'b1;
    #1;
    checks++; if (z_ready_o !== 1'b1) $display("FAIL ns_ready_comb: got %0b want 1", z_ready_o); else passed++;
    z_valid_i = 1'b1; z_data_i = ZW'(6);
    tick();
    z_valid_i = 1'b0;
    checks++; if (z_data_o !== ZW'(6) || z_occ_o !== 2'd1)
      $display("FAIL ns_d6: got data %0d occ %0d want data 6 occ 1", z_data_o, z_occ_o); else passed++;
    tick();
    checks++; if (z_valid_o !== 1'b0 || z_ctrl_o !== '0)
      $display("FAIL ns_drain: got valid %0b ctrl %h want 0 0", z_valid_o, z_ctrl_o); else passed++;
    z_valid_i = 1'b1; z_data_i = ZW'(7); z_flush_i = 1'b1;
    tick();
    z_valid_i = 1'b0; z_flush_i = 1'b0;
    checks++; if (z_valid_o !== 1'b0 || z_occ_o !== 2'd0)
      $display("FAIL ns_flush: got valid %0b occ %0d want 0 0", z_valid_o, z_occ_o); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      data_i  = {$urandom, $urandom, $urandom};
      ctrl_i  = CW'($urandom);
      tick();
      if (!valid_o) begin
        checks++; if (ctrl_o !== '0) $display("FAIL rnd_bubble_ctrl: got %h want 0", ctrl_o); else passed++;
      end
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (4) tick();
    checks++; if (sb.size() != 0) $display("FAIL rnd_drain: got %0d pending want 0", sb.size()); else passed++;
    checks++; if (valid_o !== 1'b0) $display("FAIL rnd_idle: got %0b want 0", valid_o); else passed++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_noskid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked successor to the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload and a control-bit payload between two stages using valid/ready flow control.
- Adds stall, flush (bubble insertion) and an optional two-entry skid buffer, so that downstream backpressure never creates a combinational ready path to upstream.
- Every stage boundary of the CPU instantiates this block, with the widths set per boundary.

Parameters:
DATA_W, 96, data payload width (e.g. RSdata+RTdata+immed = 96 at ID/EX)
CTRL_W, 7, control payload width (ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ALUOp[1:0])
SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o

Ports:
clk_i  in  1  clock; all state updates on its rising edge
rst_i  in  1  synchronous active-low reset, sampled on rising clk_i
valid_i  in  1  upstream payload valid
ready_o  out  1  block can accept a payload this cycle
data_i  in  DATA_W  upstream data payload
ctrl_i  in  CTRL_W  upstream control payload
flush_i  in  1  discard all held and incoming payloads (branch taken or hazard kill)
valid_o  out  1  downstream payload valid
ready_i  in  1  downstream accepts the payload this cycle
data_o  out  DATA_W  held data payload
ctrl_o  out  CTRL_W  held control payload; forced to 0 whenever valid_o=0
occ_o  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset: rst_i low at a rising edge clears every register on that edge: valid_o=0, data_o=0, ctrl_o=0, occ_o=0, skid entry invalid. ready_o=1 from the first cycle after the reset edge. Reset overrides flush and all handshakes, including mid-transfer.
- Transfer definitions: in = valid_i & ready_o & !flush_i; out = valid_o & ready_i.
- Entries: main (M, drives outputs) and skid (S, SKID=1 only). FIFO order is preserved and a payload is never duplicated or dropped, except by flush.
- SKID=1:
  - ready_o = !S.valid (registered).
  - Each edge, priority order:
    - flush_i: M and S both become invalid.
    - else if (!M.valid | out): if S.valid, M<=S and S becomes invalid; otherwise, if in, M<=input, and if not in, M becomes invalid.
    - else (M held, stalled): if in, S<=input.
  - Latency: 1 cycle from in to valid_o.
  - Sustained throughput is 1 payload per cycle when ready_i=1.
- SKID=0:
  - ready_o = !valid_o | ready_i (combinational).
  - Each edge: flush clears M; otherwise in loads M; otherwise out clears M.
- Flush:
  - Takes effect on the edge where flush_i=1.
  - valid_o=0 and ctrl_o=0 in the following cycle.
  - An input presented with flush_i=1 is not accepted, and no upstream handshake completes in that cycle.
- Bubble rule: ctrl_o is zero whenever valid_o=0, so RegWrite and MemWrite can never fire from a bubble. data_o keeps its last value when invalid (no gating).
- occ_o = M.valid + S.valid, updated with the same edge.
- Simultaneous in and out with S empty: M is replaced by the input, occ_o stays 1.
- Simultaneous in and out with S full: cannot occur, because ready_o=0.

Decomposition:
- Shared package pipe_pkg holds:
  - the control-field bit positions CTRL_ALUSRC=0, CTRL_MEMTOREG=1, CTRL_REGWRITE=2, CTRL_MEMWRITE=3, CTRL_MEMREAD=4, CTRL_ALUOP_LSB=5;
  - CTRL_W_DEFAULT=7;
  - the per-boundary DATA_W constants.
- One natural sub-module, pipe_entry: a valid+payload register with load, clear and synchronous reset. It is instantiated for M and, under a SKID generate, for S.

Test Plan:
- Reset: hold rst_i=0 for 2 edges with valid_i=1 and ctrl_i=7'h7F -> valid_o=0, ctrl_o=0, data_o=0, occ_o=0; ready_o=1 one cycle after rst_i=1.
- Streaming, SKID=1: 4 payloads D=1..4 on back-to-back cycles with ready_i=1 -> valid_o=1 with data_o=1,2,3,4 on consecutive cycles starting 1 cycle after the first accept; occ_o stays 1.
- Backpressure, SKID=1: drop ready_i after D=1 is in M, offer D=2 and D=3 -> D=2 lands in S, occ_o=2, ready_o=0, D=3 held upstream; raise ready_i -> outputs 1,2,3 in order with none lost.
- Flush: with occ_o=2 and ctrl_i=7'h04, pulse flush_i for 1 cycle with valid_i=1 -> next cycle valid_o=0, ctrl_o=0, occ_o=0; the input on the flush cycle is never emitted.
- Reset mid-operation: with occ_o=2 and ready_i=0, assert rst_i=0 for 1 edge -> all state cleared; a new payload D=9 is emitted alone 1 cycle after its accept.
- SKID=0 mode: with ready_i=0 and valid_o=1 -> ready_o=0 in the same cycle; with ready_i=1 -> ready_o=1 in the same cycle, and D=5 is replaced by D=6 in one edge.
